hazard_forward_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It tracks destination registers of instructions in flight through EX, MEM and WB, and generates registered forwarding selects for the EX-stage ALU source muxes. It also detects load-use hazards and sequences a multi-cycle MULT/DIV unit, stalling the front end and injecting bubbles into ID/EX. It sits beside the ID/EX pipeline register, consumes decoded ID-stage fields and drives the operand-select muxes in EX.

---
 rtl/hazard_forward_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage core: EX/MEM destination tracking, registered
// forwarding selects, load-use and HI/LO interlocks, and the MULT/DIV busy timer.
module hazard_forward_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ID_Valid,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic       ID_RegWrite,
  input  logic [4:0] ID_WriteReg,
  input  logic       ID_MemRead,
  input  logic       ID_MultDiv,
  input  logic       ID_UseHiLo,
  input  logic       Flush,
  output logic [1:0] AluSrcA_Sel,
  output logic [1:0] AluSrcB_Sel,
  output logic       Stall,
  output logic       EX_Bubble,
  output logic       MD_Busy
);

  localparam int MDW = $clog2(MD_LATENCY + 1);
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LATENCY);

  logic           ex_regwrite;
  logic           ex_memread;
  logic [4:0]     ex_writereg;
  logic           mem_regwrite;
  logic [4:0]     mem_writereg;
  logic [MDW-1:0] md_count;

  logic       load_use;
  logic       hilo_hazard;
  logic       issue;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

  assign MD_Busy = (md_count != '0);

  always_comb begin
    ex_hit_rs  = ex_regwrite  && (ex_writereg  != 5'd0) && (ex_writereg  == ID_rs);
    ex_hit_rt  = ex_regwrite  && (ex_writereg  != 5'd0) && (ex_writereg  == ID_rt);
    mem_hit_rs = mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == ID_rs);
    mem_hit_rt = mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == ID_rt);

    load_use    = ex_memread && ((ID_UseRs && ex_hit_rs) || (ID_UseRt && ex_hit_rt));
    hilo_hazard = MD_Busy && (ID_MultDiv || ID_UseHiLo);

    Stall     = ID_Valid && !Flush && (load_use || hilo_hazard);
    EX_Bubble = Stall || Flush;
    issue     = ID_Valid && !Stall && !Flush;

    // The EX-stage producer is newer than the MEM-stage one, so it takes priority.
    fwd_a = 2'b00;
    if (ID_UseRs && ex_hit_rs)       fwd_a = 2'b01;
    else if (ID_UseRs && mem_hit_rs) fwd_a = 2'b10;

    fwd_b = 2'b00;
    if (ID_UseRt && ex_hit_rt)       fwd_b = 2'b01;
    else if (ID_UseRt && mem_hit_rt) fwd_b = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_writereg  <= 5'd0;
      mem_regwrite <= 1'b0;
      mem_writereg <= 5'd0;
      md_count     <= '0;
      AluSrcA_Sel  <= 2'b00;
      AluSrcB_Sel  <= 2'b00;
    end else begin
      mem_regwrite <= ex_regwrite;
      mem_writereg <= ex_writereg;
      if (issue) begin
        ex_regwrite <= ID_RegWrite;
        ex_memread  <= ID_MemRead;
        ex_writereg <= ID_WriteReg;
        AluSrcA_Sel <= fwd_a;
        AluSrcB_Sel <= fwd_b;
      end else begin
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_writereg <= 5'd0;
        AluSrcA_Sel <= 2'b00;
        AluSrcB_Sel <= 2'b00;
      end
      // A flushed or stalled MULT/DIV never issues, so it cannot restart the timer.
      if (issue && ID_MultDiv)
        md_count <= MD_LOAD;
      else if (md_count != '0)
        md_count <= md_count - MDW'(1);
    end
  end

endmodule
